// File: rtl/led_pattern_gen_pkg.sv
// rtl/led_pattern_gen_pkg.sv - shared fomu LED types, channel limits and helpers
package led_pattern_gen_pkg;

  // Per-channel LED behaviour; encoding is visible to users cycling with the mode button.
  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } led_mode_t;

  // Direction of the shared breathe ramp.
  typedef enum logic {
    RAMP_UP   = 1'b0,
    RAMP_DOWN = 1'b1
  } ramp_dir_t;

  // Legal range for the CHANNELS parameter; sel is 3 bits wide, so 8 is the ceiling.
  localparam int CHANNELS_MIN = 2;
  localparam int CHANNELS_MAX = 8;

  // Mode button cycles OFF -> ON -> BLINK -> BREATHE -> OFF; the 2-bit add wraps naturally.
  function automatic led_mode_t next_mode(input led_mode_t m);
    return led_mode_t'(m + 2'd1);
  endfunction

endpackage

// File: rtl/led_pattern_gen_btn_debounce.sv
// rtl/led_pattern_gen_btn_debounce.sv - button synchroniser, debouncer and press detector
module btn_debounce #(
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic clki,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  // Counter value whose increment would reach all-ones: accepting here means the raw
  // level has differed from the stable one for 2**DEBOUNCE_BITS-1 consecutive cycles.
  localparam logic [DEBOUNCE_BITS-1:0] CNT_LAST = {{(DEBOUNCE_BITS-1){1'b1}}, 1'b0};

  logic [1:0]               sync_q;
  logic                     stable_q;
  logic [DEBOUNCE_BITS-1:0] cnt_q;

  // Two-flop synchroniser; resets to released (high) so reset exit never looks like a press.
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], btn_n};
    end
  end

  // Debounce counter, stable level and a one-cycle pulse on an accepted high-to-low change.
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b1;
      press    <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_q[1] == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q    <= '0;
        stable_q <= sync_q[1];
        // stable_q is about to flip, so its old value of 1 marks a press (1 -> 0).
        press    <= stable_q;
      end else begin
        cnt_q <= cnt_q + DEBOUNCE_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - button-driven per-channel LED pattern generator (off/on/blink/breathe)
module led_pattern_gen
  import led_pattern_gen_pkg::*;
#(
  parameter int CHANNELS      = 3,
  parameter int PWM_BITS      = 8,
  parameter int LOG2DELAY     = 21,
  parameter int RAMP_LOG2     = 12,
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic                clki,
  input  logic                rst,
  input  logic [1:0]          btn_n,
  output logic [CHANNELS-1:0] pwm,
  output logic [2:0]          sel,
  output logic [1:0]          press
);

  if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : g_bad_channels
    $error("led_pattern_gen: CHANNELS out of range");
  end

  // Level one step below the top, where an upward step reaches the maximum.
  localparam logic [PWM_BITS-1:0] LEVEL_BELOW_TOP = {{(PWM_BITS-1){1'b1}}, 1'b0};

  led_mode_t                mode_q [CHANNELS];
  logic [PWM_BITS-1:0]      pwm_cnt;
  logic [LOG2DELAY-1:0]     blink_cnt;
  logic                     blink_phase;
  logic [RAMP_LOG2-1:0]     ramp_cnt;
  logic [PWM_BITS-1:0]      level;
  ramp_dir_t                ramp_dir;

  for (genvar b = 0; b < 2; b++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_BITS(DEBOUNCE_BITS)
    ) u_btn (
      .clki  (clki),
      .rst   (rst),
      .btn_n (btn_n[b]),
      .press (press[b])
    );
  end

  // Channel selection and per-channel mode; the mode press uses the pre-advance sel.
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      sel <= 3'd0;
      for (int c = 0; c < CHANNELS; c++) begin
        mode_q[c] <= (c == 0) ? MODE_BLINK : MODE_OFF;
      end
    end else begin
      if (press[0]) begin
        sel <= (sel == 3'(CHANNELS - 1)) ? 3'd0 : sel + 3'd1;
      end
      for (int c = 0; c < CHANNELS; c++) begin
        if (press[1] && sel == 3'(c)) begin
          mode_q[c] <= next_mode(mode_q[c]);
        end
      end
    end
  end

  // Free-running timebases: PWM period, blink half-period and breathe step interval.
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      pwm_cnt     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      ramp_cnt    <= '0;
    end else begin
      pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
      blink_cnt <= blink_cnt + LOG2DELAY'(1);
      ramp_cnt  <= ramp_cnt + RAMP_LOG2'(1);
      if (&blink_cnt) begin
        blink_phase <= ~blink_phase;
      end
    end
  end

  // Triangle ramp of the shared breathe level; direction flips in the step that lands on an endpoint.
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      level    <= '0;
      ramp_dir <= RAMP_UP;
    end else if (&ramp_cnt) begin
      if (ramp_dir == RAMP_UP) begin
        level <= level + PWM_BITS'(1);
        if (level == LEVEL_BELOW_TOP) begin
          ramp_dir <= RAMP_DOWN;
        end
      end else begin
        level <= level - PWM_BITS'(1);
        if (level == PWM_BITS'(1)) begin
          ramp_dir <= RAMP_UP;
        end
      end
    end
  end

  // Registered LED drive chosen by each channel's mode.
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      pwm <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        case (mode_q[c])
          MODE_OFF:     pwm[c] <= 1'b0;
          MODE_ON:      pwm[c] <= 1'b1;
          MODE_BLINK:   pwm[c] <= blink_phase;
          MODE_BREATHE: pwm[c] <= (level > pwm_cnt);
          default:      pwm[c] <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - directed self-checking bench for led_pattern_gen
module tb_led_pattern_gen;

  logic       clki = 1'b0;
  logic       rst  = 1'b1;
  logic [1:0] btn_n = 2'b11;
  logic [2:0] pwm;
  logic [2:0] sel;
  logic [1:0] press;

  int checks = 0;
  int errors = 0;
  int cyc;
  int p0_cnt = 0;
  int p1_cnt = 0;
  int both_cnt = 0;
  int base0, base1, base_both;
  int sel_seq [4] = '{1, 2, 0, 1};

  led_pattern_gen #(
    .CHANNELS      (3),
    .PWM_BITS      (3),
    .LOG2DELAY     (3),
    .RAMP_LOG2     (1),
    .DEBOUNCE_BITS (2)
  ) dut (
    .clki  (clki),
    .rst   (rst),
    .btn_n (btn_n),
    .pwm   (pwm),
    .sel   (sel),
    .press (press)
  );

  always #5 clki = ~clki;

  // Rising edges since reset release; at the sample after edge k, cyc == k.
  always @(posedge clki or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clki) begin
    if (press[0]) p0_cnt++;
    if (press[1]) p1_cnt++;
    if (press == 2'b11) both_cnt++;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Blink phase flips on every 8th edge; pwm shows the phase held after edge k-1.
  function automatic int blink_exp(input int k);
    return ((k - 1) / 8) % 2;
  endfunction

  // Level steps every 2nd edge along 0..7..1 (period 14 steps); pwm compares it to the counter at edge k-1.
  function automatic int breathe_exp(input int k);
    int s, lvl;
    s   = ((k - 1) / 2) % 14;
    lvl = (s <= 7) ? s : 14 - s;
    return (lvl > ((k - 1) % 8)) ? 1 : 0;
  endfunction

  task automatic press_btns(input logic [1:0] mask, input int n);
    @(negedge clki);
    btn_n = ~mask;
    repeat (n) @(negedge clki);
    btn_n = 2'b11;
    repeat (12) @(negedge clki);
  endtask

  initial begin
    repeat (3) @(negedge clki);
    check("rst_pwm", pwm, 0);
    check("rst_sel", sel, 0);
    check("rst_press", press, 0);

    rst = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clki);
      check("blink0", pwm[0], blink_exp(cyc));
      check("off21", pwm[2:1], 0);
    end
    check("idle_sel", sel, 0);

    base0 = p0_cnt;
    press_btns(2'b01, 2);
    check("glitch_press", p0_cnt - base0, 0);
    check("glitch_sel", sel, 0);

    for (int i = 0; i < 4; i++) begin
      base0 = p0_cnt;
      press_btns(2'b01, 10);
      check("sel_press_cnt", p0_cnt - base0, 1);
      check("sel_seq", sel, sel_seq[i]);
    end

    base1 = p1_cnt;
    press_btns(2'b10, 10);
    check("mode_press_cnt", p1_cnt - base1, 1);
    check("ch1_on", pwm[1], 1);
    press_btns(2'b10, 10);
    press_btns(2'b10, 10);
    for (int i = 0; i < 56; i++) begin
      @(negedge clki);
      check("breathe1", pwm[1], breathe_exp(cyc));
      check("blink0_b", pwm[0], blink_exp(cyc));
    end

    press_btns(2'b01, 10);
    check("sel_to2", sel, 2);
    base_both = both_cnt;
    press_btns(2'b11, 10);
    check("both_press", both_cnt - base_both, 1);
    check("both_sel", sel, 0);
    check("ch2_on", pwm[2], 1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clki);
      check("blink0_kept", pwm[0], blink_exp(cyc));
      check("breathe1_kept", pwm[1], breathe_exp(cyc));
    end

    press_btns(2'b01, 10);
    press_btns(2'b10, 10);
    press_btns(2'b10, 10);
    check("pre_rst_sel", sel, 1);
    check("pre_rst_ch1_on", pwm[1], 1);

    @(negedge clki);
    btn_n = 2'b10;
    repeat (3) @(posedge clki);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pwm", pwm, 0);
    check("async_rst_sel", sel, 0);
    check("async_rst_press", press, 0);
    @(negedge clki);
    btn_n = 2'b11;
    repeat (3) @(negedge clki);
    base0 = p0_cnt;
    base1 = p1_cnt;
    rst = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clki);
      check("post_rst_blink0", pwm[0], blink_exp(cyc));
      check("post_rst_off21", pwm[2:1], 0);
    end
    check("post_rst_no_press0", p0_cnt - base0, 0);
    check("post_rst_no_press1", p1_cnt - base1, 0);
    check("post_rst_sel", sel, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter CHANNELS, 3, number of LED PWM outputs; legal range 2..8.
REQ-002 Parameter PWM_BITS, 8, PWM period is 2**PWM_BITS clki cycles.
REQ-003 Parameter LOG2DELAY, 21, blink half-period is 2**LOG2DELAY cycles.
REQ-004 Parameter RAMP_LOG2, 12, breathe level steps once every 2**RAMP_LOG2 cycles.
REQ-005 Parameter DEBOUNCE_BITS, 16, a button must be stable for 2**DEBOUNCE_BITS-1 cycles to be accepted.
REQ-006 clki  input  1  single system clock; all state changes on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 btn_n  input  2  raw active-low buttons, asynchronous to clki; [0]=select, [1]=mode.
REQ-009 pwm  output  CHANNELS  per-channel LED drive, active-high, registered.
REQ-010 sel  output  3  index of currently selected channel.
REQ-011 press  output  2  one-cycle pulse per accepted button press, bit order as btn_n.

Function
REQ-012 Each btn_n bit SHALL pass a 2-flop synchroniser before any other use.
REQ-013 Debounce: a per-button counter SHALL clear whenever the synchronised value equals the stable value, else increment; on reaching 2**DEBOUNCE_BITS-1 the stable value SHALL take the synchronised value and the counter clear.
REQ-014 press[i] SHALL be high for exactly the one cycle after stable[i] goes 1->0; a 0->1 transition SHALL produce no pulse.
REQ-015 Each channel SHALL hold a 2-bit mode: OFF=0, ON=1, BLINK=2, BREATHE=3.
REQ-016 press[0] SHALL advance sel by 1, wrapping CHANNELS-1 -> 0, in the cycle following the pulse.
REQ-017 press[1] SHALL advance mode[sel] by 1, wrapping BREATHE -> OFF, in the cycle following the pulse.
REQ-018 If press[0] and press[1] are high in the same cycle, the mode change SHALL apply to the channel selected before the sel advance.
REQ-019 A free-running PWM_BITS counter SHALL wrap 2**PWM_BITS-1 -> 0.
REQ-020 A free-running LOG2DELAY counter SHALL toggle blink_phase on each wrap; blink_phase resets to 0.
REQ-021 Breathe level (PWM_BITS wide, shared by all channels) SHALL step by 1 on each RAMP_LOG2 counter wrap, counting up to 2**PWM_BITS-1 then down to 0 then up; the direction reverses in the step that reaches an endpoint, so each endpoint is held for one step interval only.
REQ-022 pwm[c] SHALL be registered one cycle after its inputs: OFF -> 0; ON -> 1; BLINK -> blink_phase; BREATHE -> (level > pwm_cnt).
REQ-023 BREATHE at level 0 SHALL output constant 0; at maximum level it SHALL be low exactly one cycle per PWM period.
REQ-024 A mode change SHALL take effect on pwm in the cycle after mode updates; counters are not restarted by mode changes.

Reset
REQ-025 On rst: pwm=0, sel=0, press=0, all counters, level and blink_phase=0, breathe direction=up, synchroniser and stable values=1 (released).
REQ-026 On rst: mode[0]=BLINK, all other channels OFF.
REQ-027 rst asserted mid-debounce or mid-ramp SHALL discard that progress; no press pulse SHALL be generated by reset release.

Structure
REQ-028 The mode encoding enum and the CHANNELS legal-range constants SHALL live in the shared fomu LED package.
REQ-029 The synchroniser plus debounce plus edge detect SHALL be one sub-module, btn_debounce, instantiated twice.

Verification (CHANNELS=3, PWM_BITS=3, LOG2DELAY=3, RAMP_LOG2=1, DEBOUNCE_BITS=2)
REQ-030 Reset release, no buttons -> pwm[0] toggles every 8 cycles, pwm[2:1]=0, sel=0.
REQ-031 btn_n[0] low 2 cycles then high -> no press; low 10 cycles -> exactly one press[0] pulse, sel=1.
REQ-032 Four accepted btn_n[0] presses -> sel sequence 1,2,0,1.
REQ-033 sel=1, three btn_n[1] presses -> mode[1]=BREATHE; pwm[1] duty over 8-cycle windows rises 0..7/8 then falls, level at 7 gives 7 high of 8.
REQ-034 Both buttons accepted in the same cycle with sel=2 -> mode[2] advances, sel becomes 0, mode[0] unchanged.
REQ-035 rst pulsed while mode[1]=ON and debounce counter non-zero -> all outputs return to REQ-025/026 values asynchronously, no press pulse after release.
